// File: rtl/mem_bus_master.sv
// mem_bus_master: sequences single/burst read and write cycles on a shared 16-bit tristate memory bus.
module mem_bus_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_len,
  output logic              cpu_ready,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wvalid,
  output logic              cpu_wtake,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_done,
  output logic              enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, TURN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cur_addr, cur_addr_n, address_n;
  logic [3:0] beats_left, beats_left_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic enable_n, we_n;
  assign cpu_ready = (state == IDLE) && !rst;
  assign cpu_wtake = (state == WRITE) && cpu_wvalid;
  assign cpu_done = state == TURN;
  assign data = (enable && write_enable) ? wdata_q : {DATA_W{1'bz}};
  always_comb begin
    state_n = state;
    cur_addr_n = cur_addr;
    beats_left_n = beats_left;
    address_n = address;
    wdata_n = wdata_q;
    enable_n = 1'b0;
    we_n = 1'b0;
    case (state)
      IDLE: if (cpu_req) begin
        state_n = cpu_we ? WRITE : RD_ADDR;
        cur_addr_n = cpu_addr;
        beats_left_n = cpu_len;
      end
      WRITE: if (cpu_wvalid) begin
        enable_n = 1'b1;
        we_n = 1'b1;
        address_n = cur_addr;
        wdata_n = cpu_wdata;
        state_n = (beats_left == 4'd0) ? TURN : WRITE;
        cur_addr_n = (beats_left == 4'd0) ? cur_addr : cur_addr + ADDR_W'(1);
        beats_left_n = (beats_left == 4'd0) ? beats_left : beats_left - 4'd1;
      end
      RD_ADDR: begin
        enable_n = 1'b1;
        address_n = cur_addr;
        state_n = RD_DATA;
      end
      RD_DATA: begin
        enable_n = 1'b1;
        state_n = (beats_left == 4'd0) ? TURN : RD_ADDR;
        cur_addr_n = (beats_left == 4'd0) ? cur_addr : cur_addr + ADDR_W'(1);
        beats_left_n = (beats_left == 4'd0) ? beats_left : beats_left - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // The memory has the addressed word on the bus by the end of RD_DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_addr <= '0;
      beats_left <= '0;
      address <= '0;
      wdata_q <= '0;
      enable <= 1'b0;
      write_enable <= 1'b0;
      cpu_rdata <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      state <= state_n;
      cur_addr <= cur_addr_n;
      beats_left <= beats_left_n;
      address <= address_n;
      wdata_q <= wdata_n;
      enable <= enable_n;
      write_enable <= we_n;
      cpu_rvalid <= state == RD_DATA;
      if (state == RD_DATA) cpu_rdata <= data;
    end
  end
endmodule
